// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline hazard controller. Handles load-use bubbles,
//                redirect flushes, data-memory wait holds with timeout,
//                operand forwarding selects and stall/flush counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int REG_IDX_WIDTH = 5,
    parameter int WAIT_MAX      = 16,
    parameter int CNT_W         = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [REG_IDX_WIDTH-1:0] IDReadAddr1,
    input  logic [REG_IDX_WIDTH-1:0] IDReadAddr2,
    input  logic [REG_IDX_WIDTH-1:0] EXReadAddr1,
    input  logic [REG_IDX_WIDTH-1:0] EXReadAddr2,
    input  logic [REG_IDX_WIDTH-1:0] EXWriteAddr,
    input  logic [REG_IDX_WIDTH-1:0] MEMWriteAddr,
    input  logic [REG_IDX_WIDTH-1:0] WBWriteAddr,
    input  logic                     EXRegWrite,
    input  logic                     MEMRegWrite,
    input  logic                     WBRegWrite,
    input  logic [1:0]               EXMemtoReg,
    input  logic                     redirect,
    input  logic                     dmemReq,
    input  logic                     dmemAck,
    output logic                     PCWrite,
    output logic                     IFIDWrite,
    output logic                     IFIDFlush,
    output logic                     IDEXFlush,
    output logic                     EXMEMFlush,
    output logic                     pipeHold,
    output logic [1:0]               forwardA,
    output logic [1:0]               forwardB,
    output logic                     memTimeout,
    output logic [CNT_W-1:0]         stallCnt,
    output logic [CNT_W-1:0]         flushCnt
);

    localparam int c_WAIT_W = $clog2(WAIT_MAX + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(WAIT_MAX);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        MWAIT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state;
    logic [c_WAIT_W-1:0] r_waitCnt;
    logic                r_memTimeout;
    logic [CNT_W-1:0]    r_stallCnt;
    logic [CNT_W-1:0]    r_flushCnt;
    logic                w_loadUse;
    logic                w_memWait;
    logic                w_timeoutNow;

    // Reset forces the decode to behave as RUN during the reset cycle itself
    always_comb begin
        w_state = reset ? RUN : r_state;
    end

    assign w_loadUse = (EXMemtoReg == 2'b01) && EXRegWrite &&
                       (EXWriteAddr != '0) &&
                       ((EXWriteAddr == IDReadAddr1) || (EXWriteAddr == IDReadAddr2));

    // Memory wait term: new miss in RUN, or still waiting below the timeout in MWAIT
    always_comb begin
        w_memWait    = 1'b0;
        w_timeoutNow = 1'b0;
        if (w_state == RUN) begin
            w_memWait = dmemReq && !dmemAck;
        end else begin
            w_memWait    = !dmemAck && (r_waitCnt < c_WAIT_MAX);
            w_timeoutNow = !dmemAck && (r_waitCnt == c_WAIT_MAX);
        end
    end

    // Pipeline control decode: memory wait beats redirect beats load-use
    always_comb begin
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IFIDFlush  = 1'b0;
        IDEXFlush  = 1'b0;
        EXMEMFlush = 1'b0;
        pipeHold   = 1'b0;
        if (w_memWait) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            pipeHold  = 1'b1;
        end else if (redirect) begin
            IFIDFlush  = 1'b1;
            IDEXFlush  = 1'b1;
            EXMEMFlush = 1'b1;
        end else if (w_loadUse) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IDEXFlush = 1'b1;
        end
    end

    // Forwarding selects: MEM result is newer than WB, register 0 never forwards
    always_comb begin
        forwardA = 2'b00;
        forwardB = 2'b00;
        if (MEMRegWrite && (MEMWriteAddr != '0) && (MEMWriteAddr == EXReadAddr1))
            forwardA = 2'b10;
        else if (WBRegWrite && (WBWriteAddr != '0) && (WBWriteAddr == EXReadAddr1))
            forwardA = 2'b01;
        if (MEMRegWrite && (MEMWriteAddr != '0) && (MEMWriteAddr == EXReadAddr2))
            forwardB = 2'b10;
        else if (WBRegWrite && (WBWriteAddr != '0) && (WBWriteAddr == EXReadAddr2))
            forwardB = 2'b01;
    end

    // Wait-state FSM with wait counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= RUN;
            r_waitCnt    <= '0;
            r_memTimeout <= 1'b0;
        end else begin
            if (w_memWait) begin
                r_state   <= MWAIT;
                r_waitCnt <= (r_state == RUN) ? c_WAIT_W'(1) : r_waitCnt + 1'b1;
            end else begin
                r_state   <= RUN;
                r_waitCnt <= '0;
            end
            if (w_timeoutNow)
                r_memTimeout <= 1'b1;
        end
    end

    // Saturating performance counters for stall and flush cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else begin
            if (!PCWrite && (r_stallCnt != '1))
                r_stallCnt <= r_stallCnt + 1'b1;
            if (EXMEMFlush && (r_flushCnt != '1))
                r_flushCnt <= r_flushCnt + 1'b1;
        end
    end

    assign memTimeout = r_memTimeout;
    assign stallCnt   = r_stallCnt;
    assign flushCnt   = r_flushCnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Self-checking bench for hazard_ctrl: decode table, directed
//                wait/timeout/reset sequences and random traffic against a
//                behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int WAIT_MAX = 16;
    localparam int CNT_W    = 16;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic [4:0]       IDReadAddr1, IDReadAddr2, EXReadAddr1, EXReadAddr2;
    logic [4:0]       EXWriteAddr, MEMWriteAddr, WBWriteAddr;
    logic             EXRegWrite, MEMRegWrite, WBRegWrite;
    logic [1:0]       EXMemtoReg;
    logic             redirect, dmemReq, dmemAck;
    logic             PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, EXMEMFlush, pipeHold;
    logic [1:0]       forwardA, forwardB;
    logic             memTimeout;
    logic [CNT_W-1:0] stallCnt, flushCnt;

    hazard_ctrl #(.REG_IDX_WIDTH(5), .WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .IDReadAddr1(IDReadAddr1), .IDReadAddr2(IDReadAddr2),
        .EXReadAddr1(EXReadAddr1), .EXReadAddr2(EXReadAddr2),
        .EXWriteAddr(EXWriteAddr), .MEMWriteAddr(MEMWriteAddr), .WBWriteAddr(WBWriteAddr),
        .EXRegWrite(EXRegWrite), .MEMRegWrite(MEMRegWrite), .WBRegWrite(WBRegWrite),
        .EXMemtoReg(EXMemtoReg), .redirect(redirect), .dmemReq(dmemReq), .dmemAck(dmemAck),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush),
        .IDEXFlush(IDEXFlush), .EXMEMFlush(EXMEMFlush), .pipeHold(pipeHold),
        .forwardA(forwardA), .forwardB(forwardB), .memTimeout(memTimeout),
        .stallCnt(stallCnt), .flushCnt(flushCnt)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: whether an access is outstanding, how many hold
    // cycles it has already cost, counters and the sticky timeout.
    bit       mInWait = 1'b0;
    int       mHolds  = 0;
    int       mStall  = 0;
    int       mFlush  = 0;
    bit       mTimeout = 1'b0;
    bit       mWaitPhase, mHoldNow;
    logic [9:0] mOut;   // {PC,IFID,IFIDF,IDEXF,EXMEMF,hold,fwdA,fwdB}

    function automatic logic [1:0] fwd(input logic [4:0] src);
        if (MEMRegWrite && MEMWriteAddr != 0 && MEMWriteAddr == src) return 2'b10;
        if (WBRegWrite && WBWriteAddr != 0 && WBWriteAddr == src)    return 2'b01;
        return 2'b00;
    endfunction

    task automatic predict();
        bit lu;
        logic [5:0] ctl;
        lu = (EXMemtoReg == 2'b01) && EXRegWrite && (EXWriteAddr != 0) &&
             ((EXWriteAddr == IDReadAddr1) || (EXWriteAddr == IDReadAddr2));
        mWaitPhase = !reset && mInWait;
        mHoldNow   = mWaitPhase ? (!dmemAck && mHolds < WAIT_MAX) : (dmemReq && !dmemAck);
        if (mHoldNow)      ctl = 6'b000001;
        else if (redirect) ctl = 6'b111110;
        else if (lu)       ctl = 6'b000100;
        else               ctl = 6'b110000;
        mOut = {ctl, fwd(EXReadAddr1), fwd(EXReadAddr2)};
    endtask

    task automatic advance();
        if (reset) begin
            mInWait = 0; mHolds = 0; mStall = 0; mFlush = 0; mTimeout = 0;
        end else begin
            if (!mOut[9] && mStall < CNT_MAX) mStall++;
            if (mOut[5] && mFlush < CNT_MAX)  mFlush++;
            if (mWaitPhase && !dmemAck && mHolds == WAIT_MAX) mTimeout = 1;
            if (mHoldNow) begin
                mHolds  = mWaitPhase ? mHolds + 1 : 1;
                mInWait = 1;
            end else begin
                mHolds  = 0;
                mInWait = 0;
            end
        end
    endtask

    // One clock: inputs are already driven (posedge+1); sample mid-cycle,
    // then step the model across the edge and check registered outputs.
    task automatic runCycle(input bit useExp, input logic [9:0] e, input string tag);
        logic [9:0] act;
        #4;
        predict();
        act = {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, EXMEMFlush, pipeHold, forwardA, forwardB};
        chk({tag, " outputs-vs-model"}, 32'(act), 32'(mOut));
        if (useExp) chk({tag, " outputs-vs-table"}, 32'(act), 32'(e));
        @(posedge clk);
        advance();
        #1;
        chk({tag, " stallCnt"}, 32'(stallCnt), 32'(mStall));
        chk({tag, " flushCnt"}, 32'(flushCnt), 32'(mFlush));
        chk({tag, " memTimeout"}, 32'(memTimeout), 32'(mTimeout));
    endtask

    task automatic idleInputs();
        IDReadAddr1 = 0; IDReadAddr2 = 0; EXReadAddr1 = 0; EXReadAddr2 = 0;
        EXWriteAddr = 0; MEMWriteAddr = 0; WBWriteAddr = 0;
        EXRegWrite = 0; MEMRegWrite = 0; WBRegWrite = 0; EXMemtoReg = 2'b00;
        redirect = 0; dmemReq = 0; dmemAck = 0;
    endtask

    task automatic doReset();
        idleInputs();
        reset = 1;
        runCycle(0, '0, "reset");
        reset = 0;
    endtask

    typedef struct {
        logic [4:0] id1, id2, ex1, ex2, exW, memW, wbW;
        logic       exRW, memRW, wbRW;
        logic [1:0] m2r;
        logic       redir, req, ack;
        logic [9:0] exp;
    } vec_t;

    localparam logic [9:0] E_IDLE = 10'b1100000000;
    localparam logic [9:0] E_HOLD = 10'b0000010000;

    vec_t vecs[12];

    initial begin
        // field order: id1,id2,ex1,ex2,exW,memW,wbW, exRW,memRW,wbRW, m2r, redir,req,ack, exp
        vecs[0]  = '{0,0,0,0,0,0,0, 0,0,0, 2'b00, 0,0,0, E_IDLE};
        vecs[1]  = '{3,5,0,0,5,0,0, 1,0,0, 2'b01, 0,0,0, 10'b0001000000};
        vecs[2]  = '{0,4,0,0,0,0,0, 1,0,0, 2'b01, 0,0,0, E_IDLE};
        vecs[3]  = '{6,0,0,0,6,0,0, 1,0,0, 2'b10, 0,0,0, E_IDLE};
        vecs[4]  = '{3,5,0,0,5,0,0, 1,0,0, 2'b01, 1,0,0, 10'b1111100000};
        vecs[5]  = '{0,0,7,0,0,7,7, 0,1,1, 2'b00, 0,0,0, 10'b1100001000};
        vecs[6]  = '{0,0,0,0,0,0,0, 0,1,1, 2'b00, 0,0,0, E_IDLE};
        vecs[7]  = '{0,0,0,9,0,9,9, 0,0,1, 2'b00, 0,0,0, 10'b1100000001};
        vecs[8]  = '{0,0,2,2,0,2,2, 0,1,1, 2'b00, 0,0,0, 10'b1100001010};
        vecs[9]  = '{0,0,0,0,0,0,0, 0,0,0, 2'b00, 1,1,1, 10'b1111100000};
        vecs[10] = '{3,5,0,0,5,0,0, 0,0,0, 2'b01, 0,0,0, E_IDLE};
        vecs[11] = '{5,1,0,0,5,0,0, 1,0,0, 2'b01, 0,1,1, 10'b0001000000};

        idleInputs();
        reset = 1;
        @(posedge clk);
        #1;
        doReset();
        chk("reset stallCnt", 32'(stallCnt), 0);
        chk("reset flushCnt", 32'(flushCnt), 0);
        chk("reset memTimeout", 32'(memTimeout), 0);

        // Single-cycle decode table, all in RUN
        for (int i = 0; i < 12; i++) begin
            IDReadAddr1 = vecs[i].id1; IDReadAddr2 = vecs[i].id2;
            EXReadAddr1 = vecs[i].ex1; EXReadAddr2 = vecs[i].ex2;
            EXWriteAddr = vecs[i].exW; MEMWriteAddr = vecs[i].memW; WBWriteAddr = vecs[i].wbW;
            EXRegWrite = vecs[i].exRW; MEMRegWrite = vecs[i].memRW; WBRegWrite = vecs[i].wbRW;
            EXMemtoReg = vecs[i].m2r; redirect = vecs[i].redir;
            dmemReq = vecs[i].req; dmemAck = vecs[i].ack;
            runCycle(1, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Three-cycle memory wait released by ack
        doReset();
        dmemReq = 1; dmemAck = 0;
        for (int i = 0; i < 3; i++) runCycle(1, E_HOLD, $sformatf("wait3 c%0d", i));
        dmemAck = 1;
        runCycle(1, E_IDLE, "wait3 ack");
        chk("wait3 stallCnt", 32'(stallCnt), 3);
        dmemReq = 0; dmemAck = 0;
        runCycle(1, E_IDLE, "wait3 back-in-RUN");

        // Timeout: 16 hold cycles, release on 17th, then a fresh wait
        doReset();
        dmemReq = 1; dmemAck = 0;
        for (int i = 1; i <= 20; i++) begin
            runCycle(1, (i == 17) ? E_IDLE : E_HOLD, $sformatf("timeout c%0d", i));
            if (i == 16) chk("timeout not yet", 32'(memTimeout), 0);
            if (i == 17) chk("timeout set", 32'(memTimeout), 1);
        end
        dmemReq = 0; dmemAck = 1;
        runCycle(1, E_IDLE, "timeout ack");
        chk("timeout sticky", 32'(memTimeout), 1);

        // Reset in the second MWAIT cycle
        dmemReq = 1; dmemAck = 0;
        runCycle(1, E_HOLD, "rstwait enter");
        runCycle(1, E_HOLD, "rstwait mwait1");
        reset = 1;
        runCycle(1, E_HOLD, "rstwait reset");
        reset = 0; dmemReq = 0;
        chk("rstwait stallCnt", 32'(stallCnt), 0);
        chk("rstwait flushCnt", 32'(flushCnt), 0);
        chk("rstwait memTimeout", 32'(memTimeout), 0);
        runCycle(1, E_IDLE, "rstwait RUN");

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            reset        = ($urandom_range(0, 99) == 0);
            IDReadAddr1  = 5'($urandom_range(0, 3));
            IDReadAddr2  = 5'($urandom_range(0, 3));
            EXReadAddr1  = 5'($urandom_range(0, 3));
            EXReadAddr2  = 5'($urandom_range(0, 3));
            EXWriteAddr  = 5'($urandom_range(0, 3));
            MEMWriteAddr = 5'($urandom_range(0, 3));
            WBWriteAddr  = 5'($urandom_range(0, 3));
            EXRegWrite   = 1'($urandom_range(0, 1));
            MEMRegWrite  = 1'($urandom_range(0, 1));
            WBRegWrite   = 1'($urandom_range(0, 1));
            EXMemtoReg   = 2'($urandom_range(0, 3));
            redirect     = ($urandom_range(0, 5) == 0);
            dmemReq      = ($urandom_range(0, 1) == 0);
            dmemAck      = ($urandom_range(0, 7) == 0);
            runCycle(0, '0, $sformatf("rand%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameters SHALL be: REG_IDX_WIDTH, 5, register index width; WAIT_MAX, 16, MEM-wait timeout in cycles; CNT_W, 16, perf counter width.
REQ-002 Ports SHALL be:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- IDReadAddr1, IDReadAddr2  in  REG_IDX_WIDTH  source registers of the instruction in ID.
- EXReadAddr1, EXReadAddr2  in  REG_IDX_WIDTH  source registers of the instruction in EX.
- EXWriteAddr, MEMWriteAddr, WBWriteAddr  in  REG_IDX_WIDTH  destination registers per stage.
- EXRegWrite, MEMRegWrite, WBRegWrite  in  1  destination-write enable per stage.
- EXMemtoReg  in  2  2'b01 = instruction in EX is a load.
- redirect  in  1  branch taken or jump resolved in MEM.
- dmemReq  in  1  MEM stage is accessing data memory.
- dmemAck  in  1  data memory completes the access this cycle.
- PCWrite, IFIDWrite  out  1  1 = PC / IF-ID register advances.
- IFIDFlush, IDEXFlush, EXMEMFlush  out  1  zero the corresponding pipeline register at the next edge.
- pipeHold  out  1  freeze EX/MEM and MEM/WB registers.
- forwardA, forwardB  out  2  ALU operand source select: 00 register file, 10 MEM stage, 01 WB stage.
- memTimeout  out  1  sticky MEM-wait timeout flag.
- stallCnt, flushCnt  out  CNT_W  performance counters.

Function
REQ-003 FSM states SHALL be RUN and MWAIT, held in a registered state variable; all non-counter outputs SHALL be combinational decodes of state and inputs.
REQ-004 Default outputs in RUN: PCWrite=1, IFIDWrite=1, all flushes=0, pipeHold=0.
REQ-005 loadUse SHALL equal EXMemtoReg==2'b01 && EXRegWrite && EXWriteAddr!=0 && (EXWriteAddr==IDReadAddr1 || EXWriteAddr==IDReadAddr2).
REQ-006 Priority within RUN SHALL be: memory wait > redirect > loadUse.
REQ-007 RUN with dmemReq && !dmemAck: PCWrite=0, IFIDWrite=0, pipeHold=1, no flush; next state MWAIT; waitCnt cleared to 1.
REQ-008 RUN with redirect (no memory wait): IFIDFlush=IDEXFlush=EXMEMFlush=1, PCWrite=1 (PC loads target); loadUse ignored.
REQ-009 RUN with loadUse only: PCWrite=0, IFIDWrite=0, IDEXFlush=1 for exactly that cycle (one bubble); no state change.
REQ-010 MWAIT with !dmemAck and waitCnt<WAIT_MAX: outputs as in REQ-007; waitCnt increments.
REQ-011 MWAIT with dmemAck: outputs SHALL be decoded exactly as RUN for that cycle (REQ-006..009, memory wait term false); next state RUN.
REQ-012 MWAIT with !dmemAck and waitCnt==WAIT_MAX: memTimeout set to 1, outputs decoded as RUN; next state RUN (access abandoned).
REQ-013 forwardA SHALL be 10 if MEMRegWrite && MEMWriteAddr!=0 && MEMWriteAddr==EXReadAddr1; else 01 if WBRegWrite && WBWriteAddr!=0 && WBWriteAddr==EXReadAddr1; else 00. forwardB SHALL be identical using EXReadAddr2. MEM match SHALL take priority over WB match.
REQ-014 forwardA/B SHALL be evaluated in every state; register index 0 SHALL never forward.
REQ-015 stallCnt SHALL increment on each cycle with PCWrite=0; flushCnt SHALL increment on each cycle with EXMEMFlush=1; both SHALL saturate at all-ones.
REQ-016 memTimeout SHALL remain 1 until reset.

Reset
REQ-017 On a rising clk edge with reset=1: state=RUN, waitCnt=0, memTimeout=0, stallCnt=0, flushCnt=0, regardless of state or inputs (including mid-MWAIT).
REQ-018 While reset=1, outputs SHALL decode from state RUN with all inputs as presented.

Verification
REQ-019 Load-use: EXMemtoReg=01, EXRegWrite=1, EXWriteAddr=5, IDReadAddr2=5 for one cycle -> PCWrite=0, IFIDWrite=0, IDEXFlush=1 that cycle only; stallCnt 0->1.
REQ-020 Redirect coincident with loadUse -> IFIDFlush=IDEXFlush=EXMEMFlush=1, PCWrite=1; flushCnt 0->1; stallCnt unchanged.
REQ-021 dmemReq=1, dmemAck=0 for 3 cycles, then ack -> pipeHold=1 and PCWrite=0 for 3 cycles, released in the ack cycle; stallCnt=3; state RUN after.
REQ-022 dmemReq=1, no ack for 20 cycles (WAIT_MAX=16) -> hold for 16 cycles, released on cycle 17, memTimeout=1 and held until reset.
REQ-023 Forwarding: MEMWriteAddr=WBWriteAddr=EXReadAddr1=7, both RegWrite=1 -> forwardA=10; same with addr 0 -> forwardA=00.
REQ-024 reset asserted in 2nd MWAIT cycle -> next cycle state RUN, pipeHold=0 (dmemReq=0), counters and memTimeout 0.
